// File: rtl/data_mem_ctrl_if.sv
// Request/response channel between the load/store unit and data_mem_ctrl.
// Both channels use a valid/ready handshake.
interface data_mem_ctrl_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [1:0]  rsp_err_code;

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, rsp_err_code
  );

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, rsp_err_code
  );
endinterface

// File: rtl/data_mem_ctrl.sv
// Word-organised data memory with RV32 sub-word loads/stores, an address window,
// a registered one-cycle response stage with back-pressure, and fault reporting.
module data_mem_ctrl #(
  parameter int unsigned DEPTH     = 1024,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            reset_n,
  data_mem_ctrl_if.slave  bus
);

  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam logic [32:0] BASE33 = 33'(BASE_ADDR);
  localparam logic [32:0] LIMIT  = 33'(BASE_ADDR) + (33'(DEPTH) << 2);

  localparam logic [1:0] ERR_OK    = 2'd0;
  localparam logic [1:0] ERR_ALIGN = 2'd1;
  localparam logic [1:0] ERR_RANGE = 2'd2;
  localparam logic [1:0] ERR_F3    = 2'd3;

  typedef enum logic {S_EMPTY, S_FULL} state_e;

  state_e      r_state;
  logic [31:0] r_rdata;
  logic        r_err;
  logic [1:0]  r_err_code;
  logic [31:0] r_mem [DEPTH];

  logic             w_accept;
  logic [32:0]      w_addr33;
  logic [32:0]      w_off;
  logic             w_in_range;
  logic [IDX_W-1:0] w_idx;
  logic [1:0]       w_size;
  logic             w_illegal;
  logic             w_misaligned;
  logic [1:0]       w_code;
  logic             w_fault;
  logic             w_wr_en;
  logic [3:0]       w_be;
  logic [31:0]      w_wdata_rep;
  logic [31:0]      w_word;
  logic [31:0]      w_shift;
  logic [31:0]      w_load;
  logic [31:0]      w_rdata_nxt;
  logic             w_unused_bits;

  // A new request may enter whenever the response stage is empty or draining.
  assign bus.req_ready = (r_state == S_EMPTY) || bus.rsp_ready;
  assign w_accept      = bus.req_valid && bus.req_ready;

  assign bus.rsp_valid    = (r_state == S_FULL);
  assign bus.rsp_rdata    = r_rdata;
  assign bus.rsp_err      = r_err;
  assign bus.rsp_err_code = r_err_code;

  // Request decode: window check in 33 bits so the upper bound cannot wrap.
  always_comb begin
    w_addr33     = {1'b0, bus.req_addr};
    w_off        = w_addr33 - BASE33;
    w_in_range   = (w_addr33 >= BASE33) && (w_addr33 < LIMIT);
    w_idx        = w_off[IDX_W+1:2];
    w_size       = bus.req_funct3[1:0];
    w_illegal    = 1'b1;
    w_misaligned = 1'b0;
    w_code       = ERR_OK;

    case (bus.req_funct3)
      3'd0, 3'd1, 3'd2: w_illegal = 1'b0;
      3'd4, 3'd5:       w_illegal = bus.req_we;
      default:          w_illegal = 1'b1;
    endcase

    if (w_size == 2'b01) w_misaligned = bus.req_addr[0];
    if (w_size == 2'b10) w_misaligned = (bus.req_addr[1:0] != 2'b00);

    if (w_illegal)        w_code = ERR_F3;
    else if (w_misaligned) w_code = ERR_ALIGN;
    else if (!w_in_range)  w_code = ERR_RANGE;

    w_fault = (w_code != ERR_OK);
    w_wr_en = w_accept && bus.req_we && !w_fault;
  end

  // Store lane enables and lane-replicated write data.
  always_comb begin
    w_be        = 4'b1111;
    w_wdata_rep = bus.req_wdata;
    case (w_size)
      2'b00: begin
        w_be        = 4'b0001 << bus.req_addr[1:0];
        w_wdata_rep = {4{bus.req_wdata[7:0]}};
      end
      2'b01: begin
        w_be        = bus.req_addr[1] ? 4'b1100 : 4'b0011;
        w_wdata_rep = {2{bus.req_wdata[15:0]}};
      end
      default: begin
        w_be        = 4'b1111;
        w_wdata_rep = bus.req_wdata;
      end
    endcase
  end

  // Load extraction with sign or zero extension.
  always_comb begin
    w_word  = r_mem[w_idx];
    w_shift = w_word >> {bus.req_addr[1:0], 3'b000};
    case (bus.req_funct3)
      3'd0:    w_load = {{24{w_shift[7]}}, w_shift[7:0]};
      3'd1:    w_load = {{16{w_shift[15]}}, w_shift[15:0]};
      3'd4:    w_load = {24'd0, w_shift[7:0]};
      3'd5:    w_load = {16'd0, w_shift[15:0]};
      default: w_load = w_word;
    endcase
    w_rdata_nxt = (w_fault || bus.req_we) ? 32'd0 : w_load;
  end

  assign w_unused_bits = ^{w_off[32:IDX_W+2], w_off[1:0]};

  // Memory array is deliberately not reset.
  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      for (int i = 0; i < 4; i++) begin
        if (w_be[i]) r_mem[w_idx][8*i +: 8] <= w_wdata_rep[8*i +: 8];
      end
    end
  end

  // Response stage: EMPTY/FULL, holding while the consumer stalls.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= S_EMPTY;
      r_rdata    <= 32'd0;
      r_err      <= 1'b0;
      r_err_code <= ERR_OK;
    end else begin
      case (r_state)
        S_EMPTY: begin
          if (w_accept) begin
            r_state    <= S_FULL;
            r_rdata    <= w_rdata_nxt;
            r_err      <= w_fault;
            r_err_code <= w_code;
          end
        end
        S_FULL: begin
          if (w_accept) begin
            r_state    <= S_FULL;
            r_rdata    <= w_rdata_nxt;
            r_err      <= w_fault;
            r_err_code <= w_code;
          end else if (bus.rsp_ready) begin
            r_state <= S_EMPTY;
          end
        end
        default: r_state <= S_EMPTY;
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Testbench for data_mem_ctrl: directed scenarios plus randomized traffic
// checked against a byte-array reference model of the memory.
module tb_data_mem_ctrl;

  localparam int unsigned DEPTH = 64;
  localparam logic [31:0] BASE  = 32'h0000_1000;
  localparam int unsigned SPAN  = 4 * DEPTH;

  logic clk     = 1'b0;
  logic reset_n = 1'b0;
  int   checks  = 0;
  int   errors  = 0;

  logic [7:0]  mem_model [SPAN];
  logic [35:0] exp_r;
  logic [35:0] exp_b;

  always #5 clk = ~clk;

  data_mem_ctrl_if bus ();

  data_mem_ctrl #(.DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  function automatic logic [35:0] obs();
    return {bus.rsp_valid, bus.rsp_err, bus.rsp_err_code, bus.rsp_rdata};
  endfunction

  // Reference model: returns {valid, err, code, rdata} and updates the byte array.
  task automatic model_access(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                              input logic [31:0] wd, output logic [35:0] exp);
    int unsigned nbytes;
    int unsigned off;
    longint      a;
    logic [1:0]  code;
    logic [31:0] val;
    nbytes = 1 << f3[1:0];
    a      = longint'(addr);
    code   = 2'd0;
    val    = 32'd0;
    if ((we && f3 > 3'd2) || (!we && (f3 == 3'd3 || f3 > 3'd5))) code = 2'd3;
    else if ((addr % nbytes) != 0) code = 2'd1;
    else if (a < longint'(BASE) || a >= longint'(BASE) + longint'(SPAN)) code = 2'd2;
    if (code == 2'd0) begin
      off = addr - BASE;
      if (we) begin
        for (int k = 0; k < int'(nbytes); k++) mem_model[off + k] = wd[8*k +: 8];
      end else begin
        for (int k = 0; k < int'(nbytes); k++) val = val | (32'(mem_model[off + k]) << (8*k));
        if (!f3[2] && nbytes < 4 && val[8*nbytes - 1]) val = val | ~((32'd1 << (8*nbytes)) - 32'd1);
      end
    end
    exp = {1'b1, code != 2'd0, code, val};
  endtask

  // Present one request at a falling edge; returns at the next falling edge.
  task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wd);
    bus.req_valid  = 1'b1;
    bus.req_we     = we;
    bus.req_funct3 = f3;
    bus.req_addr   = addr;
    bus.req_wdata  = wd;
    @(negedge clk);
    bus.req_valid  = 1'b0;
  endtask

  task automatic test_reset();
    bus.req_valid  = 1'b0;
    bus.req_we     = 1'b0;
    bus.req_funct3 = 3'd0;
    bus.req_addr   = 32'd0;
    bus.req_wdata  = 32'd0;
    bus.rsp_ready  = 1'b1;
    reset_n        = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (obs() !== 36'h0) begin
      errors++; $display("FAIL reset_rsp: got %h expected %h", obs(), 36'h0);
    end
    checks++;
    if (bus.req_ready !== 1'b1) begin
      errors++; $display("FAIL reset_req_ready: got %b expected 1", bus.req_ready);
    end
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_fill();
    logic [31:0] wd;
    for (int w = 0; w < int'(DEPTH); w++) begin
      wd = $urandom;
      model_access(1'b1, 3'd2, BASE + 32'(4*w), wd, exp_r);
      issue(1'b1, 3'd2, BASE + 32'(4*w), wd);
      checks++;
      if (obs() !== exp_r) begin
        errors++; $display("FAIL fill_sw[%0d]: got %h expected %h", w, obs(), exp_r);
      end
    end
  endtask

  task automatic test_word_rw();
    model_access(1'b1, 3'd2, BASE + 32'h10, 32'h8000_00F1, exp_r);
    issue(1'b1, 3'd2, BASE + 32'h10, 32'h8000_00F1);
    checks++;
    if (obs() !== 36'h8_0000_0000) begin
      errors++; $display("FAIL sw_rsp: got %h expected %h", obs(), 36'h8_0000_0000);
    end
    checks++;
    if (bus.req_ready !== 1'b1) begin
      errors++; $display("FAIL sw_req_ready: got %b expected 1", bus.req_ready);
    end
    model_access(1'b0, 3'd2, BASE + 32'h10, 32'd0, exp_r);
    issue(1'b0, 3'd2, BASE + 32'h10, 32'd0);
    checks++;
    if (obs() !== 36'h8_8000_00F1) begin
      errors++; $display("FAIL lw_after_sw: got %h expected %h", obs(), 36'h8_8000_00F1);
    end
    checks++;
    if (bus.req_ready !== 1'b1) begin
      errors++; $display("FAIL lw_req_ready: got %b expected 1", bus.req_ready);
    end
  endtask

  task automatic test_subword();
    logic [15:0] low_before;
    model_access(1'b1, 3'd0, BASE + 32'h13, 32'h0000_00AB, exp_r);
    issue(1'b1, 3'd0, BASE + 32'h13, 32'h0000_00AB);
    model_access(1'b0, 3'd0, BASE + 32'h13, 32'd0, exp_r);
    issue(1'b0, 3'd0, BASE + 32'h13, 32'd0);
    checks++;
    if (obs() !== 36'h8_FFFF_FFAB) begin
      errors++; $display("FAIL lb: got %h expected %h", obs(), 36'h8_FFFF_FFAB);
    end
    model_access(1'b0, 3'd4, BASE + 32'h13, 32'd0, exp_r);
    issue(1'b0, 3'd4, BASE + 32'h13, 32'd0);
    checks++;
    if (obs() !== 36'h8_0000_00AB) begin
      errors++; $display("FAIL lbu: got %h expected %h", obs(), 36'h8_0000_00AB);
    end
    model_access(1'b0, 3'd2, BASE + 32'h10, 32'd0, exp_r);
    issue(1'b0, 3'd2, BASE + 32'h10, 32'd0);
    checks++;
    if (obs() !== 36'h8_AB00_00F1) begin
      errors++; $display("FAIL lw_after_sb: got %h expected %h", obs(), 36'h8_AB00_00F1);
    end
    model_access(1'b0, 3'd2, BASE + 32'h20, 32'd0, exp_r);
    low_before = exp_r[15:0];
    model_access(1'b1, 3'd1, BASE + 32'h22, 32'h1234_8001, exp_r);
    issue(1'b1, 3'd1, BASE + 32'h22, 32'h1234_8001);
    model_access(1'b0, 3'd1, BASE + 32'h22, 32'd0, exp_r);
    issue(1'b0, 3'd1, BASE + 32'h22, 32'd0);
    checks++;
    if (obs() !== 36'h8_FFFF_8001) begin
      errors++; $display("FAIL lh: got %h expected %h", obs(), 36'h8_FFFF_8001);
    end
    model_access(1'b0, 3'd5, BASE + 32'h22, 32'd0, exp_r);
    issue(1'b0, 3'd5, BASE + 32'h22, 32'd0);
    checks++;
    if (obs() !== 36'h8_0000_8001) begin
      errors++; $display("FAIL lhu: got %h expected %h", obs(), 36'h8_0000_8001);
    end
    model_access(1'b0, 3'd2, BASE + 32'h20, 32'd0, exp_r);
    issue(1'b0, 3'd2, BASE + 32'h20, 32'd0);
    checks++;
    if (obs() !== {4'h8, 16'h8001, low_before}) begin
      errors++; $display("FAIL lw_after_sh: got %h expected %h", obs(), {4'h8, 16'h8001, low_before});
    end
  endtask

  task automatic test_faults();
    model_access(1'b0, 3'd2, BASE + 32'h2, 32'd0, exp_r);
    issue(1'b0, 3'd2, BASE + 32'h2, 32'd0);
    checks++;
    if (obs() !== 36'hD_0000_0000) begin
      errors++; $display("FAIL lw_misaligned: got %h expected %h", obs(), 36'hD_0000_0000);
    end
    model_access(1'b1, 3'd2, BASE + SPAN, 32'hDEAD_BEEF, exp_r);
    issue(1'b1, 3'd2, BASE + SPAN, 32'hDEAD_BEEF);
    checks++;
    if (obs() !== 36'hE_0000_0000) begin
      errors++; $display("FAIL sw_out_of_range: got %h expected %h", obs(), 36'hE_0000_0000);
    end
    // Index of an out-of-range address aliases word 0; it must be untouched.
    model_access(1'b0, 3'd2, BASE, 32'd0, exp_r);
    issue(1'b0, 3'd2, BASE, 32'd0);
    checks++;
    if (obs() !== exp_r || obs() === 36'h8_DEAD_BEEF) begin
      errors++; $display("FAIL probe_after_oor_sw: got %h expected %h", obs(), exp_r);
    end
    issue(1'b0, 3'd3, BASE, 32'd0);
    checks++;
    if (obs() !== 36'hF_0000_0000) begin
      errors++; $display("FAIL load_f3_3: got %h expected %h", obs(), 36'hF_0000_0000);
    end
    issue(1'b1, 3'd2, BASE + SPAN + 32'd1, 32'h1111_1111);
    checks++;
    if (obs() !== 36'hD_0000_0000) begin
      errors++; $display("FAIL sw_misaligned_oor: got %h expected %h", obs(), 36'hD_0000_0000);
    end
    issue(1'b1, 3'd4, BASE + 32'h40, 32'h2222_2222);
    checks++;
    if (obs() !== 36'hF_0000_0000) begin
      errors++; $display("FAIL store_f3_4: got %h expected %h", obs(), 36'hF_0000_0000);
    end
    issue(1'b0, 3'd2, BASE - 32'd4, 32'd0);
    checks++;
    if (obs() !== 36'hE_0000_0000) begin
      errors++; $display("FAIL lw_below_base: got %h expected %h", obs(), 36'hE_0000_0000);
    end
    model_access(1'b0, 3'd4, BASE + SPAN - 32'd1, 32'd0, exp_r);
    issue(1'b0, 3'd4, BASE + SPAN - 32'd1, 32'd0);
    checks++;
    if (obs() !== exp_r) begin
      errors++; $display("FAIL lbu_last_byte: got %h expected %h", obs(), exp_r);
    end
  endtask

  task automatic test_random();
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wd;
    for (int i = 0; i < 300; i++) begin
      we = 1'($urandom_range(0, 1));
      f3 = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 15) == 0) addr = $urandom;
      else addr = BASE - 32'd8 + 32'($urandom_range(0, SPAN + 15));
      wd = $urandom;
      model_access(we, f3, addr, wd, exp_r);
      issue(we, f3, addr, wd);
      checks++;
      if (obs() !== exp_r) begin
        errors++;
        $display("FAIL random[%0d] we=%b f3=%0d addr=%h: got %h expected %h",
                 i, we, f3, addr, obs(), exp_r);
      end
    end
  endtask

  task automatic test_back_pressure();
    model_access(1'b0, 3'd2, BASE + 32'h10, 32'd0, exp_r);
    issue(1'b0, 3'd2, BASE + 32'h10, 32'd0);
    checks++;
    if (obs() !== exp_r) begin
      errors++; $display("FAIL bp_first: got %h expected %h", obs(), exp_r);
    end
    bus.rsp_ready  = 1'b0;
    bus.req_valid  = 1'b1;
    bus.req_we     = 1'b0;
    bus.req_funct3 = 3'd5;
    bus.req_addr   = BASE + 32'h22;
    bus.req_wdata  = 32'd0;
    #1;
    checks++;
    if (bus.req_ready !== 1'b0) begin
      errors++; $display("FAIL bp_req_ready_low: got %b expected 0", bus.req_ready);
    end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++;
      if (obs() !== exp_r || bus.req_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold[%0d]: got rsp %h ready %b expected rsp %h ready 0",
                 c, obs(), bus.req_ready, exp_r);
      end
    end
    bus.rsp_ready = 1'b1;
    #1;
    checks++;
    if (bus.req_ready !== 1'b1) begin
      errors++; $display("FAIL bp_release_ready: got %b expected 1", bus.req_ready);
    end
    model_access(1'b0, 3'd5, BASE + 32'h22, 32'd0, exp_b);
    @(negedge clk);
    bus.req_valid = 1'b0;
    checks++;
    if (obs() !== exp_b) begin
      errors++; $display("FAIL bp_next_accepted: got %h expected %h", obs(), exp_b);
    end
    @(negedge clk);
    checks++;
    if (bus.rsp_valid !== 1'b0) begin
      errors++; $display("FAIL bp_drain: got rsp_valid %b expected 0", bus.rsp_valid);
    end
  endtask

  task automatic test_async_reset();
    bus.rsp_ready = 1'b0;
    model_access(1'b1, 3'd2, BASE + 32'h30, 32'h5A5A_1234, exp_r);
    issue(1'b1, 3'd2, BASE + 32'h30, 32'h5A5A_1234);
    checks++;
    if (bus.rsp_valid !== 1'b1) begin
      errors++; $display("FAIL ar_pending: got rsp_valid %b expected 1", bus.rsp_valid);
    end
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if (obs() !== 36'h0) begin
      errors++; $display("FAIL ar_immediate_clear: got %h expected %h", obs(), 36'h0);
    end
    @(negedge clk);
    reset_n       = 1'b1;
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    model_access(1'b0, 3'd2, BASE + 32'h30, 32'd0, exp_r);
    issue(1'b0, 3'd2, BASE + 32'h30, 32'd0);
    checks++;
    if (obs() !== 36'h8_5A5A_1234) begin
      errors++; $display("FAIL ar_persist: got %h expected %h", obs(), 36'h8_5A5A_1234);
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_word_rw();
    test_subword();
    test_faults();
    test_random();
    test_back_pressure();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
